// File: rtl/gray_dec_if.sv
// Gray decoder bus: sample strobe and Gray input going in, decoded binary and
// status coming out.
//   En, GrayIn              : driven by the source (master)
//   Binary, Up, Down,
//   Overflow, Error         : driven by the decoder (slave)
interface gray_dec_if #(
  parameter int WIDTH = 3
);
  logic             En;
  logic [WIDTH-1:0] GrayIn;
  logic [WIDTH-1:0] Binary;
  logic             Up;
  logic             Down;
  logic             Overflow;
  logic             Error;

  modport master (
    output En, GrayIn,
    input  Binary, Up, Down, Overflow, Error
  );

  modport slave (
    input  En, GrayIn,
    output Binary, Up, Down, Overflow, Error
  );
endinterface

// File: rtl/gray_decoder.sv
// gray_decoder: receive end of a Gray-code counter link.
// Samples GrayIn on En=1 cycles, converts it to binary, pulses Up/Down on
// single steps, keeps a sticky Overflow on the forward max->0 wrap, and
// enters FAULT (Error=1) when more than one bit changes between samples.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : synchronous, active-high reset
//   bus    : gray_dec_if.slave (En, GrayIn in; Binary, Up, Down, Overflow, Error out)
// Build option:
//   GRAY_DEC_RESYNC_EN : when defined, an En=1 sample in FAULT returns the FSM
//                        to SYNC (that sample is dropped). When undefined,
//                        FAULT is left only by Reset.
module gray_decoder #(
  parameter int WIDTH = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  gray_dec_if.slave  bus
);

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] bin_q;
  logic             up_q, down_q, ovf_q;

  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] bin_new, diff, bin_inc, bin_dec;
  logic             same, one_bit, is_inc, is_dec, is_wrap;

  // bin_q is always dec(prev), so the stored binary doubles as dec(prev).
  always_comb begin
    bin_new = dec(bus.GrayIn);
    diff    = bus.GrayIn ^ prev;
    bin_inc = bin_q + 1'b1;
    bin_dec = bin_q - 1'b1;
    same    = (diff == '0);
    one_bit = !same && ((diff & (diff - 1'b1)) == '0);
    is_inc  = one_bit && (bin_new == bin_inc);
    is_dec  = one_bit && (bin_new == bin_dec);
    is_wrap = is_inc && (bin_new == '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= SYNC;
      prev   <= '0;
      bin_q  <= '0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      if (bus.En) begin
        case (state)
          SYNC: begin
            prev  <= bus.GrayIn;
            bin_q <= bin_new;
            state <= TRACK;
          end
          TRACK: begin
            if (is_inc) begin
              up_q  <= 1'b1;
              prev  <= bus.GrayIn;
              bin_q <= bin_new;
              if (is_wrap) ovf_q <= 1'b1;
            end else if (is_dec) begin
              down_q <= 1'b1;
              prev   <= bus.GrayIn;
              bin_q  <= bin_new;
            end else if (!same && !one_bit) begin
              state <= FAULT;
            end
            // A single-bit change that is not a +/-1 step (only possible for
            // WIDTH>2) is treated as noise: nothing is updated.
          end
          FAULT: begin
`ifdef GRAY_DEC_RESYNC_EN
            state <= SYNC;
`else
            state <= FAULT;
`endif
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

  assign bus.Binary   = bin_q;
  assign bus.Up       = up_q;
  assign bus.Down     = down_q;
  assign bus.Overflow = ovf_q;
  assign bus.Error    = (state == FAULT);

endmodule
